// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side logic: arbiter state encoding,
// default buffer geometry and a constant-evaluable clog2 helper.
package fifo_pkg;

    // Default FIFO geometry; the depth is always 2**width.
    localparam int DEF_BUFFER_WIDTH = 3;
    localparam int DEF_BUFFER_SIZE  = 8;

    // Write-arbiter states.
    //   IDLE  : nothing eligible this cycle
    //   ISSUE : one write presented to the FIFO this cycle
    //   STALL : a producer is waiting but the FIFO has no room
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } arb_state_e;

    // Ceiling log2, usable in parameter and port-width expressions.
    // Returns at least 1 so that index buses are never zero-width.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >>> 1;
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_select.sv
// Round-robin selector: rotates the eligible vector so that rr_ptr lands on
// bit 0, picks the lowest set bit, then rotates the result back into an
// absolute producer index. Purely combinational.
module rr_select
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_index
);

    logic [NUM_REQ-1:0] w_rotated;
    logic [IDX_W-1:0]   w_offset;
    logic [IDX_W-1:0]   w_index;

    // Anything eligible at all means a winner exists.
    assign o_valid = |i_eligible;
    assign o_index = w_index;

    // Rotate: bit j of w_rotated is producer (rr_ptr + j) mod NUM_REQ.
    // Written as a pointer-decoded mux so every select index is a constant.
    always_comb begin
        w_rotated = '0;
        for (int p = 0; p < NUM_REQ; p++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                w_rotated[j] = w_rotated[j]
                             | ((i_rr_ptr == IDX_W'(p)) & i_eligible[(p + j) % NUM_REQ]);
            end
        end
    end

    // Priority-encode the rotated vector: lowest offset wins, so scan from
    // the top and let lower offsets overwrite.
    always_comb begin
        w_offset = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_offset = w_rotated[off] ? IDX_W'(off) : w_offset;
        end
    end

    // Unrotate: absolute index = (rr_ptr + offset) mod NUM_REQ, again as a
    // decoded table so non-power-of-two NUM_REQ wraps correctly.
    always_comb begin
        w_index = '0;
        for (int p = 0; p < NUM_REQ; p++) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                w_index = w_index
                        | ({IDX_W{(i_rr_ptr == IDX_W'(p)) && (w_offset == IDX_W'(off))}}
                           & IDX_W'((p + off) % NUM_REQ));
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
// Issues at most one registered write per cycle, never one that could
// overflow the FIFO, and acknowledges the winner with a one-hot grant.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH,
    parameter int BUFFER_SIZE  = DEF_BUFFER_SIZE
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_Data,
    input  logic [BUFFER_WIDTH:0]         counter,
    input  logic                          read_Enable,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          write_Enable,
    output logic [DATA_WIDTH-1:0]         write_Data,
    output logic [clog2(NUM_REQ)-1:0]     grant_Id,
    output logic                          stall
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam logic [BUFFER_WIDTH+1:0] SIZE_V = (BUFFER_WIDTH + 2)'(BUFFER_SIZE);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_REQ - 1);

    // Registered state and outputs.
    arb_state_e              r_state;
    logic [NUM_REQ-1:0]      r_grant;
    logic                    r_write_en;
    logic [DATA_WIDTH-1:0]   r_write_data;
    logic [IDX_W-1:0]        r_grant_id;
    logic [IDX_W-1:0]        r_rr_ptr;

    // Combinational decode.
    logic [NUM_REQ-1:0]      w_eligible;
    logic [BUFFER_WIDTH+1:0] w_fill;
    logic                    w_space;
    logic                    w_sel_valid;
    logic [IDX_W-1:0]        w_sel_idx;
    logic [NUM_REQ-1:0]      w_sel_onehot;
    logic [DATA_WIDTH-1:0]   w_sel_data;

    arb_state_e              w_next_state;
    logic [NUM_REQ-1:0]      w_next_grant;
    logic                    w_next_write_en;
    logic [DATA_WIDTH-1:0]   w_next_write_data;
    logic [IDX_W-1:0]        w_next_grant_id;
    logic [IDX_W-1:0]        w_next_rr_ptr;

    // read_Enable is deliberately not credited towards free space: the FIFO
    // favours the write when both strobes coincide, so a pending read does
    // not guarantee a slot. It is kept on the port for the FIFO interface.
    logic w_unused_read_enable;
    assign w_unused_read_enable = read_Enable;

    // The grant issued last cycle doubles as the mask: that producer may
    // still hold a stale req this cycle and must not be accepted twice.
    assign w_eligible = req & ~r_grant;

    // Occupancy including a write issued last cycle that counter has not
    // caught up with yet. One extra bit keeps 8+1 from wrapping.
    assign w_fill  = {1'b0, counter} + {{(BUFFER_WIDTH + 1){1'b0}}, r_write_en};
    assign w_space = (w_fill < SIZE_V);

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .o_valid    (w_sel_valid),
        .o_index    (w_sel_idx)
    );

    // Decode the winning index into a one-hot grant and its data word.
    always_comb begin
        w_sel_onehot = '0;
        w_sel_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_onehot[i] = (w_sel_idx == IDX_W'(i));
            w_sel_data      = w_sel_data
                            | ({DATA_WIDTH{w_sel_idx == IDX_W'(i)}}
                               & req_Data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Next state and next registered outputs. The rule is the same from
    // every state, so STALL naturally persists until space reappears.
    always_comb begin
        w_next_state      = IDLE;
        w_next_grant      = '0;
        w_next_write_en   = 1'b0;
        w_next_write_data = '0;
        w_next_grant_id   = r_grant_id;
        w_next_rr_ptr     = r_rr_ptr;
        if (w_sel_valid && w_space) begin
            w_next_state      = ISSUE;
            w_next_grant      = w_sel_onehot;
            w_next_write_en   = 1'b1;
            w_next_write_data = w_sel_data;
            w_next_grant_id   = w_sel_idx;
            if (w_sel_idx == LAST_IDX) begin
                w_next_rr_ptr = '0;
            end else begin
                w_next_rr_ptr = w_sel_idx + IDX_W'(1);
            end
        end else if (w_sel_valid) begin
            w_next_state = STALL;
        end else begin
            w_next_state = IDLE;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_write_en   <= 1'b0;
            r_write_data <= '0;
            r_grant_id   <= '0;
            r_rr_ptr     <= '0;
        end else begin
            r_state      <= w_next_state;
            r_grant      <= w_next_grant;
            r_write_en   <= w_next_write_en;
            r_write_data <= w_next_write_data;
            r_grant_id   <= w_next_grant_id;
            r_rr_ptr     <= w_next_rr_ptr;
        end
    end

    assign grant        = r_grant;
    assign write_Enable = r_write_en;
    assign write_Data   = r_write_data;
    assign grant_Id     = r_grant_id;
    assign stall        = (r_state == STALL);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: reset checks, a directed
// vector table (round-robin, full boundary, drop, single producer), a
// mid-burst reset sequence and randomized traffic against a reference model.
module tb_fifo_write_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_WIDTH  = 8;
    localparam int BUFFER_SIZE = 8;
    localparam logic [31:0] DATA_WORDS = 32'hA3A2A1A0;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_Data;
    logic [3:0]  counter;
    logic        read_Enable;
    logic [3:0]  grant;
    logic        write_Enable;
    logic [7:0]  write_Data;
    logic [1:0]  grant_Id;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_write_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DATA_WIDTH),
        .BUFFER_WIDTH (3),
        .BUFFER_SIZE  (BUFFER_SIZE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_Data     (req_Data),
        .counter      (counter),
        .read_Enable  (read_Enable),
        .grant        (grant),
        .write_Enable (write_Enable),
        .write_Data   (write_Data),
        .grant_Id     (grant_Id),
        .stall        (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model, kept as plain integers: pointer, last winner, outputs.
    int         m_ptr;
    int         m_masked;
    logic [3:0] m_grant;
    logic       m_we;
    logic [7:0] m_data;
    int         m_id;
    logic       m_stall;

    task automatic model_reset();
        m_ptr = 0; m_masked = -1; m_grant = 4'd0; m_we = 1'b0;
        m_data = 8'd0; m_id = 0; m_stall = 1'b0;
    endtask

    // One clock edge of the arbitration rules with the sampled inputs.
    task automatic model_edge(input logic [3:0] r, input logic [31:0] d, input int cnt);
        int k;
        k = -1;
        for (int n = 0; n < NUM_REQ; n++) begin
            int c;
            c = (m_ptr + n) % NUM_REQ;
            if (k < 0 && r[c] && c != m_masked) k = c;
        end
        if (k >= 0 && (cnt + int'(m_we)) < BUFFER_SIZE) begin
            m_grant  = 4'(1 << k);
            m_we     = 1'b1;
            m_data   = 8'(d >> (8 * k));
            m_id     = k;
            m_stall  = 1'b0;
            m_ptr    = (k + 1) % NUM_REQ;
            m_masked = k;
        end else begin
            m_grant  = 4'd0;
            m_we     = 1'b0;
            m_data   = 8'd0;
            m_stall  = (k >= 0);
            m_masked = -1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive inputs, take one edge (model follows), then settle before checks.
    task automatic cycle(input logic rst_v, input logic [3:0] r, input logic [31:0] d,
                         input logic [3:0] cnt, input logic rd);
        reset = rst_v; req = r; req_Data = d; counter = cnt; read_Enable = rd;
        @(posedge clock);
        if (!rst_v) model_reset();
        else model_edge(r, d, int'(cnt));
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".grant"}, 32'(grant), 32'(m_grant));
        check({tag, ".we"},    32'(write_Enable), 32'(m_we));
        check({tag, ".data"},  32'(write_Data), 32'(m_data));
        check({tag, ".id"},    32'(grant_Id), 32'(m_id));
        check({tag, ".stall"}, 32'(stall), 32'(m_stall));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".grant"}, 32'(grant), 32'd0);
        check({tag, ".we"},    32'(write_Enable), 32'd0);
        check({tag, ".data"},  32'(write_Data), 32'd0);
        check({tag, ".id"},    32'(grant_Id), 32'd0);
        check({tag, ".stall"}, 32'(stall), 32'd0);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] cnt;
        logic [3:0] grant;
        logic       we;
        logic [7:0] data;
        logic [1:0] id;
        logic       stall;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] r, input logic [3:0] c, input logic [3:0] g,
                                input logic w, input logic [7:0] dt, input logic [1:0] i,
                                input logic s);
        vec_t v;
        v.req = r; v.cnt = c; v.grant = g; v.we = w; v.data = dt; v.id = i; v.stall = s;
        vecs.push_back(v);
    endfunction

    initial begin
        reset = 1'b0; req = 4'd0; req_Data = 32'd0; counter = 4'd0; read_Enable = 1'b0;
        model_reset();
        #1;

        // Reset held for two edges with every producer requesting.
        cycle(1'b0, 4'b1111, DATA_WORDS, 4'd0, 1'b0);
        check_zero("reset1");
        cycle(1'b0, 4'b1111, DATA_WORDS, 4'd0, 1'b0);
        check_zero("reset2");

        // Directed table, starting from the reset state.
        //   req      cnt    grant    we    data    id    stall
        add(4'b1111, 4'd0, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b0); // round-robin
        add(4'b1111, 4'd0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b0);
        add(4'b1111, 4'd1, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b0);
        add(4'b1111, 4'd2, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b0);
        add(4'b1111, 4'd3, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b0);
        add(4'b1111, 4'd4, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b0);
        add(4'b1111, 4'd5, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b0);
        add(4'b1111, 4'd6, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b0); // 6+1 still fits
        add(4'b1111, 4'd7, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b1); // 7+1 full -> stall
        add(4'b1111, 4'd8, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b1); // full
        add(4'b1111, 4'd8, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b1);
        add(4'b1111, 4'd7, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b0); // space again
        add(4'b1111, 4'd8, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1);
        add(4'b0010, 4'd8, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1); // req[1] during stall
        add(4'b0010, 4'd8, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1);
        add(4'b0000, 4'd8, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0); // dropped
        add(4'b0000, 4'd5, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        add(4'b1111, 4'd5, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b0); // pointer still 1
        add(4'b0100, 4'd5, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b0); // single producer
        add(4'b0100, 4'd5, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0); // masked
        add(4'b0100, 4'd5, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b0);
        add(4'b0100, 4'd5, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0);

        for (int v = 0; v < vecs.size(); v++) begin
            cycle(1'b1, vecs[v].req, DATA_WORDS, vecs[v].cnt, 1'b0);
            check($sformatf("vec%0d.grant", v), 32'(grant), 32'(vecs[v].grant));
            check($sformatf("vec%0d.we", v),    32'(write_Enable), 32'(vecs[v].we));
            check($sformatf("vec%0d.data", v),  32'(write_Data), 32'(vecs[v].data));
            check($sformatf("vec%0d.id", v),    32'(grant_Id), 32'(vecs[v].id));
            check($sformatf("vec%0d.stall", v), 32'(stall), 32'(vecs[v].stall));
        end

        // Stall is not released by read_Enable alone while the FIFO is full.
        cycle(1'b1, 4'b1111, DATA_WORDS, 4'd8, 1'b1);
        cycle(1'b1, 4'b1111, DATA_WORDS, 4'd8, 1'b1);
        check("rd_stall.stall", 32'(stall), 32'd1);
        check("rd_stall.we", 32'(write_Enable), 32'd0);

        // Mid-burst reset: a write is in flight when reset hits.
        cycle(1'b0, 4'b1111, DATA_WORDS, 4'd0, 1'b0);
        cycle(1'b1, 4'b1111, DATA_WORDS, 4'd0, 1'b0);
        check("burst1.grant", 32'(grant), 32'h1);
        cycle(1'b1, 4'b1111, DATA_WORDS, 4'd0, 1'b0);
        check("burst2.grant", 32'(grant), 32'h2);
        check("burst2.we", 32'(write_Enable), 32'd1);
        cycle(1'b0, 4'b1111, DATA_WORDS, 4'd1, 1'b0);
        check_zero("midreset");
        cycle(1'b1, 4'b1111, DATA_WORDS, 4'd1, 1'b0);
        check("resume.grant", 32'(grant), 32'h1);
        check("resume.data", 32'(write_Data), 32'hA0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic       rst_v;
            logic [3:0] r;
            logic [3:0] c;
            rst_v = ($urandom_range(0, 63) != 0);
            r     = 4'($urandom);
            c     = 4'($urandom_range(0, 8));
            cycle(rst_v, r, $urandom, c, 1'($urandom));
            check_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
